rl_ram_1rw_pm_easic_n3x: RTL and testbench

- Next-generation eASIC Nextreme-3 single-port (1RW) RAM wrapper.
- Adds real byte-enable handling, an optional output register and a req/ready handshake.
- Adds an idle-driven power-management FSM that drives the macro's LS/DS/SD pins and sequences wake-up.
- Sits between bus-side memory controllers (caches, scratchpads) and the eip_n3x_bram_sp_array primitive.

---
 rtl/rl_ram_pkg.sv | 39 +++
 rtl/eip_n3x_bram_sp_array.sv | 48 ++++
 rtl/rl_ram_pm_fsm.sv | 146 ++++++++++++++
 rtl/rl_ram_1rw_pm_easic_n3x.sv | 110 +++++++++++
 tb/tb_rl_ram_1rw_pm_easic_n3x.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rl_ram_pkg.sv
// Shared types, encodings and helpers for the rl_ram power-managed RAM wrapper.
package rl_ram_pkg;

  // Internal power-management FSM states.
  typedef enum logic [2:0] {
    ACTIVE,
    LS,
    DS,
    SD,
    WAKE
  } pm_state_t;

  // Externally visible pm_state encodings.
  localparam logic [1:0] PM_ACTIVE = 2'd0;
  localparam logic [1:0] PM_LS     = 2'd1;
  localparam logic [1:0] PM_DS     = 2'd2;
  localparam logic [1:0] PM_SD     = 2'd3;

  // Counter widths for the idle and wake counters.
  localparam int IDLE_W = 16;
  localparam int WAKE_W = 8;

  // Widest data path the byte-enable helper can expand.
  localparam int MAX_DBITS = 256;
  localparam int MAX_BYTES = MAX_DBITS / 8;

  // Expand one enable bit per byte lane into a per-bit write mask.
  // Bits at or above dbits stay 0, so a partial top lane is truncated.
  function automatic logic [MAX_DBITS-1:0] be2bitmask(input logic [MAX_BYTES-1:0] be,
                                                      input int dbits);
    logic [MAX_DBITS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DBITS; i++) begin
      if (i < dbits) m[i] = be[i/8];
    end
    return m;
  endfunction

endpackage

// File: rtl/eip_n3x_bram_sp_array.sv
// Behavioural model of the Nextreme-3 single-port block RAM primitive.
// Per-bit write enables, optional output register, LS/DS/SD power pins
// that block accesses while asserted.
module eip_n3x_bram_sp_array #(
  parameter int    ADDR_WIDTH = 10,
  parameter int    DATA_WIDTH = 32,
  parameter string REG_OUT    = "NO"
) (
  input  logic                  CLK,
  input  logic                  ME,
  input  logic                  RST_N,
  input  logic                  CE,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] BWE,
  input  logic                  LS,
  input  logic                  DS,
  input  logic                  SD,
  output logic [DATA_WIDTH-1:0] Q
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic                  en;

  assign en = CE & ME & ~LS & ~DS & ~SD;

  // Masked write into the array.
  always_ff @(posedge CLK) begin
    if (en && WE) mem_q[A] <= (mem_q[A] & ~BWE) | (D & BWE);
  end

  // Synchronous read port.
  always_ff @(posedge CLK) begin
    if (en && !WE) rd_q <= mem_q[A];
  end

  // Optional output pipeline register.
  always_ff @(posedge CLK) begin
    if (!RST_N) out_q <= '0;
    else        out_q <= rd_q;
  end

  assign Q = (REG_OUT == "YES") ? out_q : rd_q;

endmodule

// File: rtl/rl_ram_pm_fsm.sv
// Idle-driven power-management FSM: counts idle cycles, drives the macro
// LS/DS/SD pins, sequences wake-up and gates ready.
module rl_ram_pm_fsm import rl_ram_pkg::*; #(
  parameter int LS_IDLE = 16,
  parameter int DS_IDLE = 256,
  parameter int WAKE_LS = 1,
  parameter int WAKE_DS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic       sd_req_i,
  input  logic       rd_busy_i,
  output logic       ready_o,
  output logic [1:0] pm_state_o,
  output logic       ls_o,
  output logic       ds_o,
  output logic       sd_o
);

  localparam bit LS_EN = (LS_IDLE != 0);
  localparam bit DS_EN = LS_EN && (DS_IDLE != 0);
  localparam logic [IDLE_W-1:0] LS_THR = IDLE_W'(LS_IDLE);
  localparam logic [IDLE_W-1:0] DS_THR = IDLE_W'(DS_IDLE);
  localparam logic [WAKE_W-1:0] WLS    = WAKE_W'(WAKE_LS);
  localparam logic [WAKE_W-1:0] WDS    = WAKE_W'(WAKE_DS);

  pm_state_t         state_q;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic [IDLE_W-1:0] idle_cnt_d;
  logic [WAKE_W-1:0] wake_cnt_q;
  logic              ready_q;
  logic [1:0]        pm_q;
  logic              ls_q;
  logic              ds_q;
  logic              sd_q;

  // Saturating idle increment.
  assign idle_cnt_d = (&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + 1'b1;

  // Power FSM with registered ready, pm_state and power pins.
  // Priority within a cycle: rst > sd_req > req > idle threshold.
  // During WAKE pm_q keeps the code of the state being exited.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACTIVE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      ready_q    <= 1'b1;
      pm_q       <= PM_ACTIVE;
      ls_q       <= 1'b0;
      ds_q       <= 1'b0;
      sd_q       <= 1'b0;
    end else begin
      case (state_q)
        ACTIVE: begin
          if (sd_req_i && !rd_busy_i) begin
            state_q    <= SD;
            idle_cnt_q <= '0;
            ready_q    <= 1'b0;
            pm_q       <= PM_SD;
            sd_q       <= 1'b1;
          end else if (req_i) begin
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_d;
            if (LS_EN && (idle_cnt_d >= LS_THR) && !rd_busy_i) begin
              state_q <= LS;
              ready_q <= 1'b0;
              pm_q    <= PM_LS;
              ls_q    <= 1'b1;
            end
          end
        end
        LS: begin
          if (sd_req_i) begin
            state_q <= SD;
            pm_q    <= PM_SD;
            ls_q    <= 1'b0;
            sd_q    <= 1'b1;
          end else if (req_i) begin
            state_q    <= WAKE;
            wake_cnt_q <= WLS;
            ls_q       <= 1'b0;
          end else begin
            idle_cnt_q <= idle_cnt_d;
            if (DS_EN && (idle_cnt_d >= DS_THR)) begin
              state_q <= DS;
              pm_q    <= PM_DS;
              ls_q    <= 1'b0;
              ds_q    <= 1'b1;
            end
          end
        end
        DS: begin
          if (sd_req_i) begin
            state_q <= SD;
            pm_q    <= PM_SD;
            ds_q    <= 1'b0;
            sd_q    <= 1'b1;
          end else if (req_i) begin
            state_q    <= WAKE;
            wake_cnt_q <= WDS;
            ds_q       <= 1'b0;
          end
        end
        SD: begin
          if (!sd_req_i) begin
            state_q    <= WAKE;
            wake_cnt_q <= WDS;
            sd_q       <= 1'b0;
          end
        end
        WAKE: begin
          // The cycle holding count 1 (or 0) is the last wake cycle.
          if (wake_cnt_q <= WAKE_W'(1)) begin
            state_q    <= ACTIVE;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
            ready_q    <= 1'b1;
            pm_q       <= PM_ACTIVE;
          end else begin
            wake_cnt_q <= wake_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q    <= ACTIVE;
          idle_cnt_q <= '0;
          wake_cnt_q <= '0;
          ready_q    <= 1'b1;
          pm_q       <= PM_ACTIVE;
          ls_q       <= 1'b0;
          ds_q       <= 1'b0;
          sd_q       <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign pm_state_o = pm_q;
  assign ls_o       = ls_q;
  assign ds_o       = ds_q;
  assign sd_o       = sd_q;

endmodule

// File: rtl/rl_ram_1rw_pm_easic_n3x.sv
// Single-port RAM wrapper for the Nextreme-3 block RAM: byte enables,
// optional output register, req/ready handshake and power management.
//
// Handshake: an access happens on a clk edge where req=1 and ready=1.
// The requester keeps req/we/addr/be/din stable until it sees ready=1.
// A read returns dout_vld (one-cycle pulse) 1 cycle after the access edge,
// or 2 cycles when REG_OUT=1; dout holds the last read data otherwise.
module rl_ram_1rw_pm_easic_n3x import rl_ram_pkg::*; #(
  parameter int ABITS   = 10,
  parameter int DBITS   = 32,
  parameter int REG_OUT = 0,
  parameter int LS_IDLE = 16,
  parameter int DS_IDLE = 256,
  parameter int WAKE_LS = 1,
  parameter int WAKE_DS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     we,
  input  logic [ABITS-1:0]         addr,
  input  logic [(DBITS+7)/8-1:0]   be,
  input  logic [DBITS-1:0]         din,
  output logic                     ready,
  output logic [DBITS-1:0]         dout,
  output logic                     dout_vld,
  input  logic                     sd_req,
  output logic [1:0]               pm_state
);

  localparam int NBYTES = (DBITS + 7) / 8;

  logic                 access;
  logic                 rd_acc;
  logic [1:0]           vld_q;
  logic                 rd_busy;
  logic [DBITS-1:0]     hold_q;
  logic [DBITS-1:0]     q;
  logic [MAX_BYTES-1:0] be_ext;
  logic [DBITS-1:0]     bwe;
  logic                 ls_pin;
  logic                 ds_pin;
  logic                 sd_pin;

  assign access = req & ready;
  assign rd_acc = access & ~we;

  // Zero-extend the byte enables to the helper's fixed width.
  always_comb begin
    be_ext = '0;
    be_ext[NBYTES-1:0] = be;
  end

  assign bwe = DBITS'(be2bitmask(be_ext, DBITS));

  rl_ram_pm_fsm #(
    .LS_IDLE (LS_IDLE),
    .DS_IDLE (DS_IDLE),
    .WAKE_LS (WAKE_LS),
    .WAKE_DS (WAKE_DS)
  ) u_pm_fsm (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .sd_req_i   (sd_req),
    .rd_busy_i  (rd_busy),
    .ready_o    (ready),
    .pm_state_o (pm_state),
    .ls_o       (ls_pin),
    .ds_o       (ds_pin),
    .sd_o       (sd_pin)
  );

  eip_n3x_bram_sp_array #(
    .ADDR_WIDTH (ABITS),
    .DATA_WIDTH (DBITS),
    .REG_OUT    ((REG_OUT != 0) ? "YES" : "NO")
  ) u_bram (
    .CLK   (clk),
    .ME    (1'b1),
    .RST_N (1'b1),
    .CE    (access),
    .WE    (we),
    .A     (addr),
    .D     (din),
    .BWE   (bwe),
    .LS    (ls_pin),
    .DS    (ds_pin),
    .SD    (sd_pin),
    .Q     (q)
  );

  // Read-valid shift register tracking reads in flight through the macro.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[0], rd_acc};
  end

  assign dout_vld = (REG_OUT != 0) ? vld_q[1] : vld_q[0];
  assign rd_busy  = (REG_OUT != 0) ? (|vld_q) : vld_q[0];

  // Hold register keeps the last read data visible between reads.
  always_ff @(posedge clk) begin
    if (rst)           hold_q <= '0;
    else if (dout_vld) hold_q <= q;
  end

  assign dout = dout_vld ? q : hold_q;

endmodule

// File: tb/tb_rl_ram_1rw_pm_easic_n3x.sv
// Directed bench for the power-managed single-port RAM wrapper.
module tb_rl_ram_1rw_pm_easic_n3x;

  localparam int REG_OUT_P = 0;
  localparam int LAT       = (REG_OUT_P != 0) ? 2 : 1;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [9:0]  addr;
  logic [3:0]  be;
  logic [31:0] din;
  logic        ready;
  logic [31:0] dout;
  logic        dout_vld;
  logic        sd_req;
  logic [1:0]  pm_state;

  int pass_cnt;
  int total_cnt;

  logic [31:0] pdat [3];

  rl_ram_1rw_pm_easic_n3x #(
    .ABITS   (10),
    .DBITS   (32),
    .REG_OUT (REG_OUT_P),
    .LS_IDLE (16),
    .DS_IDLE (256),
    .WAKE_LS (1),
    .WAKE_DS (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .be       (be),
    .din      (din),
    .ready    (ready),
    .dout     (dout),
    .dout_vld (dout_vld),
    .sd_req   (sd_req),
    .pm_state (pm_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: one-cycle write request (RAM must be ACTIVE).
  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    req  = 1'b1;
    we   = 1'b1;
    addr = a;
    din  = d;
    be   = b;
  endtask

  // Driver: present a read request (caller removes it).
  task automatic drive_read(input logic [9:0] a);
    @(negedge clk);
    req  = 1'b1;
    we   = 1'b0;
    addr = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else pass_cnt++;
    total_cnt++;
    if (pm_state !== 2'd0) $display("FAIL reset_pm: got %0d expected 0", pm_state); else pass_cnt++;
    total_cnt++;
    if (dout !== 32'h0) $display("FAIL reset_dout: got %h expected 00000000", dout); else pass_cnt++;
    total_cnt++;
    if (dout_vld !== 1'b0) $display("FAIL reset_vld: got %b expected 0", dout_vld); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_byte_enable();
    do_write(10'd5, 32'hAABBCCDD, 4'b1111);
    do_write(10'd5, 32'h11223344, 4'b0101);
    drive_read(10'd5);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      req = 1'b0;
      total_cnt++;
      if (dout_vld !== (k == LAT)) $display("FAIL be_vld_lat%0d: got %b expected %b", k, dout_vld, (k == LAT));
      else pass_cnt++;
    end
    total_cnt++;
    if (dout !== 32'hAA22CC44) $display("FAIL be_data: got %h expected aa22cc44", dout); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (dout_vld !== 1'b0) $display("FAIL be_vld_pulse: got %b expected 0", dout_vld); else pass_cnt++;
    total_cnt++;
    if (dout !== 32'hAA22CC44) $display("FAIL be_hold: got %h expected aa22cc44", dout); else pass_cnt++;
  endtask

  task automatic test_pipelined_reads();
    pdat[0] = 32'h1111_0001;
    pdat[1] = 32'h2222_0002;
    pdat[2] = 32'h3333_0003;
    do_write(10'd1, pdat[0], 4'hF);
    do_write(10'd2, pdat[1], 4'hF);
    do_write(10'd3, pdat[2], 4'hF);
    for (int c = 0; c <= LAT + 3; c++) begin
      @(negedge clk);
      total_cnt++;
      if (dout_vld !== ((c >= LAT) && (c < LAT + 3)))
        $display("FAIL pipe_vld_c%0d: got %b expected %b", c, dout_vld, ((c >= LAT) && (c < LAT + 3)));
      else pass_cnt++;
      if ((c >= LAT) && (c < LAT + 3)) begin
        total_cnt++;
        if (dout !== pdat[c-LAT]) $display("FAIL pipe_data_c%0d: got %h expected %h", c, dout, pdat[c-LAT]);
        else pass_cnt++;
      end else if (c >= LAT + 3) begin
        total_cnt++;
        if (dout !== pdat[2]) $display("FAIL pipe_hold: got %h expected %h", dout, pdat[2]);
        else pass_cnt++;
      end
      if (c < 3) begin
        req  = 1'b1;
        we   = 1'b0;
        addr = 10'(c + 1);
      end else begin
        req = 1'b0;
      end
    end
  endtask

  task automatic test_idle_entry();
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    total_cnt++;
    if (pm_state !== 2'd0) $display("FAIL idle15_pm: got %0d expected 0", pm_state); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (pm_state !== 2'd1) $display("FAIL idle16_pm: got %0d expected 1", pm_state); else pass_cnt++;
    total_cnt++;
    if (ready !== 1'b0) $display("FAIL idle16_ready: got %b expected 0", ready); else pass_cnt++;
    repeat (239) @(negedge clk);
    total_cnt++;
    if (pm_state !== 2'd1) $display("FAIL idle255_pm: got %0d expected 1", pm_state); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (pm_state !== 2'd2) $display("FAIL idle256_pm: got %0d expected 2", pm_state); else pass_cnt++;
  endtask

  task automatic test_wake_ds();
    int  n;
    bit  got;
    logic [1:0] wake_pm;
    n = 0;
    got = 1'b0;
    wake_pm = 2'd0;
    drive_read(10'd5);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (k == 0) wake_pm = pm_state;
      if (ready === 1'b1) got = 1'b1;
      else n++;
    end
    total_cnt++;
    if (!got) $display("FAIL ds_wake_timeout: got ready=%b expected 1", ready); else pass_cnt++;
    total_cnt++;
    if (n != 4) $display("FAIL ds_wake_cycles: got %0d expected 4", n); else pass_cnt++;
    total_cnt++;
    if (wake_pm !== 2'd2) $display("FAIL ds_wake_pm: got %0d expected 2", wake_pm); else pass_cnt++;
    total_cnt++;
    if (pm_state !== 2'd0) $display("FAIL ds_active_pm: got %0d expected 0", pm_state); else pass_cnt++;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      req = 1'b0;
      total_cnt++;
      if (dout_vld !== (k == LAT)) $display("FAIL ds_vld_lat%0d: got %b expected %b", k, dout_vld, (k == LAT));
      else pass_cnt++;
    end
    total_cnt++;
    if (dout !== 32'hAA22CC44) $display("FAIL ds_data: got %h expected aa22cc44", dout); else pass_cnt++;
  endtask

  task automatic test_shutdown();
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (pm_state === 2'd1) got = 1'b1;
    end
    total_cnt++;
    if (!got) $display("FAIL sd_ls_timeout: got pm=%0d expected 1", pm_state); else pass_cnt++;
    sd_req = 1'b1;
    req    = 1'b1;
    we     = 1'b1;
    addr   = 10'd7;
    din    = 32'hDEAD_BEEF;
    be     = 4'hF;
    @(negedge clk);
    total_cnt++;
    if (pm_state !== 2'd3) $display("FAIL sd_enter_pm: got %0d expected 3", pm_state); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (ready !== 1'b0) $display("FAIL sd_ready: got %b expected 0", ready); else pass_cnt++;
    total_cnt++;
    if (pm_state !== 2'd3) $display("FAIL sd_hold_pm: got %0d expected 3", pm_state); else pass_cnt++;
    sd_req = 1'b0;
    req    = 1'b0;
    got    = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (ready === 1'b1) got = 1'b1;
      else n++;
    end
    total_cnt++;
    if (n != 4) $display("FAIL sd_wake_cycles: got %0d expected 4", n); else pass_cnt++;
    total_cnt++;
    if (pm_state !== 2'd0) $display("FAIL sd_active_pm: got %0d expected 0", pm_state); else pass_cnt++;
    drive_read(10'd5);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      req = 1'b0;
      total_cnt++;
      if (dout_vld !== (k == LAT)) $display("FAIL sd_vld_lat%0d: got %b expected %b", k, dout_vld, (k == LAT));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    sd_req = 1'b1;
    @(negedge clk);
    sd_req = 1'b0;
    total_cnt++;
    if (pm_state !== 2'd3) $display("FAIL rm_sd_pm: got %0d expected 3", pm_state); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (ready !== 1'b0) $display("FAIL rm_wake_ready: got %b expected 0", ready); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (pm_state !== 2'd0) $display("FAIL rm_wake_pm: got %0d expected 0", pm_state); else pass_cnt++;
    total_cnt++;
    if (ready !== 1'b1) $display("FAIL rm_wake_rdy: got %b expected 1", ready); else pass_cnt++;
    total_cnt++;
    if (dout !== 32'h0) $display("FAIL rm_wake_dout: got %h expected 00000000", dout); else pass_cnt++;
    total_cnt++;
    if (dout_vld !== 1'b0) $display("FAIL rm_wake_vld: got %b expected 0", dout_vld); else pass_cnt++;
    drive_read(10'd5);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (dout_vld !== 1'b0) $display("FAIL rm_rd_vld: got %b expected 0", dout_vld); else pass_cnt++;
    total_cnt++;
    if (dout !== 32'h0) $display("FAIL rm_rd_dout: got %h expected 00000000", dout); else pass_cnt++;
    total_cnt++;
    if (ready !== 1'b1 || pm_state !== 2'd0)
      $display("FAIL rm_rd_state: got ready=%b pm=%0d expected ready=1 pm=0", ready, pm_state);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (dout_vld !== 1'b0) $display("FAIL rm_rd_vld_late: got %b expected 0", dout_vld); else pass_cnt++;
  endtask

  // Test sequence and final report
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst    = 1'b1;
    req    = 1'b0;
    we     = 1'b0;
    addr   = '0;
    be     = '0;
    din    = '0;
    sd_req = 1'b0;
    test_reset();
    test_byte_enable();
    test_pipelined_reads();
    test_idle_entry();
    test_wake_ds();
    test_shutdown();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
